fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the reduced RISC-V core.
- Owns the PC register. Issues one fetch request at a time and presents each fetched instruction downstream with a valid/ready handshake.
- Applies branch redirects from execute. Any fetch that is in flight or buffered when a redirect arrives is discarded.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_INC, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
branch_valid  input  1  redirect request from execute, single-cycle qualifier
branch_PC  input  ADDRESS_WIDTH  redirect target, sampled when branch_valid=1
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDRESS_WIDTH  fetch address, equals PC
imem_ack  input  1  memory completes the request this cycle; ignored when imem_req=0
imem_rdata  input  DATA_WIDTH  instruction word, valid when imem_ack=1
instr  output  DATA_WIDTH  fetched instruction to decode
instr_PC  output  ADDRESS_WIDTH  address instr was fetched from
instr_valid  output  1  instr/instr_PC valid
instr_ready  input  1  decode accepts instr this cycle
PC  output  ADDRESS_WIDTH  current PC register

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values while rst=1 at an edge:
  - PC=RESET_PC, state=FETCH, pend=0.
  - instr=0, instr_PC=0, instr_valid=0.
  - imem_req is combinationally 0 during rst.
- Reset mid-operation overrides everything. Any outstanding ack in that cycle is ignored.
- Alignment: branch_PC[1:0] are forced to 0 before loading into PC or pend_target.
- States: FETCH, VALID.
- FETCH:
  - imem_req=1, imem_addr=PC, instr_valid=0.
  - imem_addr holds stable until imem_ack. imem_req is never dropped without an ack (memory must complete).
  - No ack, branch_valid=1: pend<=1, pend_target<=branch_PC. A newer branch_valid overwrites pend_target.
  - Ack, no branch_valid, pend=0: instr<=imem_rdata, instr_PC<=PC, PC<=PC+PC_INC, go to VALID.
  - Ack, with branch_valid=1 or pend=1: discard rdata, stay in FETCH, pend<=0.
    - If branch_valid=1: PC<=branch_PC (current branch beats pend_target).
    - Otherwise: PC<=pend_target.
- VALID:
  - imem_req=0, instr_valid=1. instr and instr_PC are held stable until the handshake completes.
  - instr_ready=1, no branch: go to FETCH; PC is already advanced.
  - branch_valid=1: PC<=branch_PC, go to FETCH.
    - With instr_ready=0, the instruction is flushed: instr_valid drops next cycle.
    - With instr_ready=1 in the same cycle, the handshake counts as completed and the redirect is still taken.
- Latency: zero-wait memory (ack in the request cycle) gives instr_valid on the next cycle. With ready=1 constant, peak throughput is one instruction every 2 cycles.
- Arithmetic: PC+PC_INC wraps modulo 2^ADDRESS_WIDTH, with no overflow flag. PC output is the registered value.
- Invariant: instr_valid and imem_req are never both 1.

Test Plan:
- Reset then free-run (ack same cycle, ready=1): imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses every 2nd cycle. instr_PC matches the address fetched.
- Memory stall (ack delayed 3 cycles at PC=0x8): imem_req=1 and imem_addr=0x8 held for 4 cycles. Instruction then presented with instr_PC=0x8, PC=0xC.
- Backpressure (ready=0 for 5 cycles in VALID): instr, instr_PC and instr_valid stay stable. No imem_req. Fetch resumes the cycle after ready=1.
- Branch during stall: branch_PC=0x100 while waiting, then branch_PC=0x203 one cycle later, then ack. rdata is discarded (no instr_valid). Next imem_addr=0x200.
- Branch in VALID with ready=0: instr_valid drops next cycle. Next imem_addr=branch_PC. Also branch_valid coincident with ack: rdata dropped, PC=branch target.
- Wrap and reset: PC=0xFFFFFFFC, fetch completes, then PC=0x0. Assert rst during a stalled fetch: next cycle PC=RESET_PC, instr_valid=0, a late ack is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Owns the PC and runs one instruction fetch at a time, handing each word to decode over valid/ready.
// A redirect from execute discards any fetch that is in flight or held.
module fetch_sequencer #(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
   parameter int                       PC_INC        = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     branch_valid,
   input  logic [ADDRESS_WIDTH-1:0] branch_PC,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_ack,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_PC,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [ADDRESS_WIDTH-1:0] PC
);

   localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(PC_INC);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_VALID = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
   logic                       pend_q, pend_d;
   logic [ADDRESS_WIDTH-1:0]   pend_target_q, pend_target_d;
   logic [DATA_WIDTH-1:0]      instr_q, instr_d;
   logic [ADDRESS_WIDTH-1:0]   instr_pc_q, instr_pc_d;
   logic [ADDRESS_WIDTH-1:0]   branch_tgt;

   // Targets are word aligned; the low two bits of the redirect are dropped.
   assign branch_tgt = {branch_PC[ADDRESS_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_d        = pend_q;
      pend_target_d = pend_target_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      imem_req      = 1'b0;
      instr_valid   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = !rst;
            if (imem_ack) begin
               if (branch_valid) begin
                  pc_d   = branch_tgt;
                  pend_d = 1'b0;
               end else if (pend_q) begin
                  pc_d   = pend_target_q;
                  pend_d = 1'b0;
               end else begin
                  instr_d    = imem_rdata;
                  instr_pc_d = pc_q;
                  pc_d       = pc_q + PC_STEP;
                  state_d    = S_VALID;
               end
            end else if (branch_valid) begin
               // The request cannot be withdrawn, so remember where to go once it completes.
               pend_d        = 1'b1;
               pend_target_d = branch_tgt;
            end
         end
         S_VALID: begin
            instr_valid = 1'b1;
            if (branch_valid) begin
               pc_d    = branch_tgt;
               state_d = S_FETCH;
            end else if (instr_ready) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         pend_q        <= 1'b0;
         pend_target_q <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         pend_target_q <= pend_target_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   assign imem_addr = pc_q;
   assign PC        = pc_q;
   assign instr     = instr_q;
   assign instr_PC  = instr_pc_q;

endmodule
